// File: rtl/wb_prog_loader.sv
// Wishbone classic slave that loads, reads back and controls the MCU core array's
// instruction memories: one-cycle write strobes, 1-cycle-latency reads, control regs.
module wb_prog_loader #(
    parameter int          CORES       = 4,
    parameter int          LOG_CORES   = 2,
    parameter int          PC_WIDTH    = 6,
    parameter int          INSTR_WIDTH = 32,
    parameter int          WB_WIDTH    = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [WB_WIDTH-1:0]    wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [WB_WIDTH-1:0]    wbs_dat_o,
    output logic [CORES-1:0]       prog_we,
    output logic [PC_WIDTH-1:0]    prog_addr,
    output logic [INSTR_WIDTH-1:0] prog_data,
    output logic                   prog_rd_en,
    output logic [LOG_CORES-1:0]   prog_rd_core,
    input  logic [INSTR_WIDTH-1:0] prog_rd_data,
    output logic [CORES-1:0]       core_en,
    output logic [CORES-1:0]       core_rst,
    input  logic [CORES-1:0]       core_halted
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP, ACK} state_t;

    state_t                 r_state;
    logic                   r_ack;
    logic [WB_WIDTH-1:0]    r_dat;
    logic [CORES-1:0]       r_prog_we;
    logic [PC_WIDTH-1:0]    r_prog_addr;
    logic [INSTR_WIDTH-1:0] r_prog_data;
    logic                   r_rd_en;
    logic [LOG_CORES-1:0]   r_rd_core;
    logic                   r_rd_valid;
    logic [CORES-1:0]       r_core_en;
    logic [CORES-1:0]       r_core_rst;

    logic                   w_req;
    logic                   w_ctrl;
    logic                   w_full_word;
    logic [PC_WIDTH-1:0]    w_pc;
    logic [LOG_CORES-1:0]   w_core;
    logic                   w_core_valid;
    logic [1:0]             w_offset;
    logic [WB_WIDTH-1:0]    w_ctrl_rdata;
    logic                   w_unused;

    assign w_req        = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
    assign w_ctrl       = wbs_adr_i[12];
    assign w_full_word  = (wbs_sel_i == 4'hF);
    assign w_pc         = wbs_adr_i[2 +: PC_WIDTH];
    assign w_core       = wbs_adr_i[2 + PC_WIDTH +: LOG_CORES];
    assign w_core_valid = (32'(w_core) < CORES);
    assign w_offset     = wbs_adr_i[3:2];
    assign w_unused     = &{1'b0, wbs_adr_i, wbs_dat_i};

    always_comb begin
        w_ctrl_rdata = '0;
        case (w_offset)
            2'd0:    w_ctrl_rdata = WB_WIDTH'(r_core_en);
            2'd2:    w_ctrl_rdata = WB_WIDTH'(core_halted);
            default: w_ctrl_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_prog_we   <= '0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_rd_en     <= 1'b0;
            r_rd_core   <= '0;
            r_rd_valid  <= 1'b0;
            r_core_en   <= '0;
            r_core_rst  <= '0;
        end else begin
            // Strobes and ack are single-cycle pulses unless re-armed below.
            r_ack      <= 1'b0;
            r_prog_we  <= '0;
            r_rd_en    <= 1'b0;
            r_core_rst <= '0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (wbs_we_i) begin
                            r_ack   <= 1'b1;
                            r_dat   <= '0;
                            r_state <= ACK;
                            if (w_full_word) begin
                                if (!w_ctrl) begin
                                    if (w_core_valid) begin
                                        r_prog_we   <= CORES'(1) << w_core;
                                        r_prog_addr <= w_pc;
                                        r_prog_data <= wbs_dat_i[INSTR_WIDTH-1:0];
                                    end
                                end else if (w_offset == 2'd0) begin
                                    r_core_en <= wbs_dat_i[CORES-1:0];
                                end else if (w_offset == 2'd1) begin
                                    r_core_rst <= wbs_dat_i[CORES-1:0];
                                end
                            end
                        end else if (w_ctrl) begin
                            r_ack   <= 1'b1;
                            r_dat   <= w_ctrl_rdata;
                            r_state <= ACK;
                        end else begin
                            r_rd_en     <= 1'b1;
                            r_rd_core   <= w_core;
                            r_prog_addr <= w_pc;
                            r_rd_valid  <= w_core_valid;
                            r_state     <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: r_state <= RD_CAP;
                RD_CAP: begin
                    // A master that dropped cyc has abandoned the read: no ack.
                    if (wbs_cyc_i) begin
                        r_ack   <= 1'b1;
                        r_dat   <= r_rd_valid ? WB_WIDTH'(prog_rd_data) : '0;
                        r_state <= ACK;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o    = r_ack;
    assign wbs_dat_o    = r_dat;
    assign prog_we      = r_prog_we;
    assign prog_addr    = r_prog_addr;
    assign prog_data    = r_prog_data;
    assign prog_rd_en   = r_rd_en;
    assign prog_rd_core = r_rd_core;
    assign core_en      = r_core_en;
    assign core_rst     = r_core_rst;

endmodule

// File: tb/tb_wb_prog_loader.sv
// Directed bench for wb_prog_loader: instruction write/read, control regs,
// partial-select and out-of-window writes, and reset during a read.
module tb_wb_prog_loader;

    logic        clk;
    logic        srst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic [3:0]  prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic        prog_rd_en;
    logic [1:0]  prog_rd_core;
    logic [31:0] prog_rd_data;
    logic [3:0]  core_en, core_rst, core_halted;

    int checks = 0;
    int failures = 0;

    // Pulse monitors, sampled on the falling edge.
    int          we_pulses, rd_pulses, rst_pulses, ack_total, bad_cycles;
    logic [3:0]  last_we, last_rst;
    logic [5:0]  last_we_addr;
    logic [31:0] last_we_data;
    logic [1:0]  last_rd_core;
    logic [31:0] mem [4][64];

    wb_prog_loader dut (
        .wb_clk_i(clk), .wb_rst_i(srst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_rd_en(prog_rd_en), .prog_rd_core(prog_rd_core), .prog_rd_data(prog_rd_data),
        .core_en(core_en), .core_rst(core_rst), .core_halted(core_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-memory model: synchronous write and 1-cycle read.
    always @(posedge clk) begin
        for (int c = 0; c < 4; c++)
            if (prog_we[c]) mem[c][prog_addr] <= prog_data;
        if (prog_rd_en) prog_rd_data <= mem[prog_rd_core][prog_addr];
    end

    always @(negedge clk) begin
        if (prog_we != 4'd0) begin
            we_pulses++; last_we = prog_we; last_we_addr = prog_addr; last_we_data = prog_data;
        end
        if (prog_rd_en) begin
            rd_pulses++; last_rd_core = prog_rd_core;
        end
        if (core_rst != 4'd0) begin
            rst_pulses++; last_rst = core_rst;
        end
        if (ack) ack_total++;
        if ($countones(prog_we) > 1 || (prog_we != 4'd0 && prog_rd_en)) bad_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clear_mon();
        we_pulses = 0; rd_pulses = 0; rst_pulses = 0;
        last_we = '0; last_rst = '0; last_we_addr = '0; last_we_data = '0; last_rd_core = '0;
    endtask

    // One bus transaction; lat = cycle index of ack after edge N (0 = none within 8),
    // ack2 = ack level one cycle after the ack cycle.
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d, output int lat, output logic [31:0] rdata,
                           output logic ack2);
        @(negedge clk);
        adr = a; we = w; sel = s; dat_i = d; stb = 1'b1; cyc = 1'b1;
        lat = 0; rdata = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = i; rdata = dat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        ack2 = ack;
        $display("xfer adr=0x%08h we=%0b sel=0x%h dat=0x%08h lat=%0d rdata=0x%08h",
                 a, w, s, d, lat, rdata);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        a2;
    int          acks_before;

    initial begin
        srst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 0; dat_i = 0; adr = 0;
        core_halted = 4'b0000; prog_rd_data = '0;
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < 64; p++) mem[c][p] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_prog", {prog_we, prog_addr, prog_rd_en, prog_rd_core}, 32'd0);
        check("rst_prog_data", prog_data, 32'd0);
        check("rst_core", {24'd0, core_en, core_rst}, 32'd0);
        srst = 1'b0;
        ack_total = 0; bad_cycles = 0;
        repeat (20) @(posedge clk);
        #1;
        check("idle_no_ack", ack_total, 32'd0);

        // Instruction write, core 1 pc 2
        clear_mon();
        wb_xfer(32'h3000_0108, 1'b1, 4'hF, 32'hDEAD_BEEF, lat, rd, a2);
        check("iw_lat", lat, 32'd1);
        check("iw_ack_one_cycle", {31'd0, a2}, 32'd0);
        check("iw_we_pulses", we_pulses, 32'd1);
        check("iw_we", {28'd0, last_we}, 32'h2);
        check("iw_addr", {26'd0, last_we_addr}, 32'd2);
        check("iw_data", last_we_data, 32'hDEAD_BEEF);

        // Read it back
        clear_mon();
        wb_xfer(32'h3000_0108, 1'b0, 4'hF, 32'd0, lat, rd, a2);
        check("ir_lat", lat, 32'd3);
        check("ir_data", rd, 32'hDEAD_BEEF);
        check("ir_rd_pulses", rd_pulses, 32'd1);
        check("ir_rd_core", {30'd0, last_rd_core}, 32'd1);
        check("ir_no_we", we_pulses, 32'd0);

        // Core 3
        wb_xfer(32'h3000_0308, 1'b1, 4'hF, 32'hCAFE_F00D, lat, rd, a2);
        check("iw3_we", {28'd0, last_we}, 32'h8);
        clear_mon();
        wb_xfer(32'h3000_0308, 1'b0, 4'hF, 32'd0, lat, rd, a2);
        check("ir3_rd_core", {30'd0, last_rd_core}, 32'd3);
        check("ir3_data", rd, 32'hCAFE_F00D);

        // Control registers
        wb_xfer(32'h3000_1000, 1'b1, 4'hF, 32'h5, lat, rd, a2);
        check("en_lat", lat, 32'd1);
        check("en_val", {28'd0, core_en}, 32'h5);
        clear_mon();
        wb_xfer(32'h3000_1004, 1'b1, 4'hF, 32'h2, lat, rd, a2);
        check("rst_pulse_cycles", rst_pulses, 32'd1);
        check("rst_pulse_val", {28'd0, last_rst}, 32'h2);
        check("rst_en_kept", {28'd0, core_en}, 32'h5);
        core_halted = 4'b1001;
        wb_xfer(32'h3000_1008, 1'b0, 4'hF, 32'd0, lat, rd, a2);
        check("status_lat", lat, 32'd1);
        check("status_val", rd, 32'h9);
        wb_xfer(32'h3000_1004, 1'b0, 4'hF, 32'd0, lat, rd, a2);
        check("rstreg_reads0", rd, 32'h0);
        wb_xfer(32'h3000_1000, 1'b0, 4'hF, 32'd0, lat, rd, a2);
        check("en_readback", rd, 32'h5);

        // Partial select: acked, no side effect, read data cleared
        clear_mon();
        wb_xfer(32'h3000_0010, 1'b1, 4'b0011, 32'h1234_5678, lat, rd, a2);
        check("sel_lat", lat, 32'd1);
        check("sel_no_we", we_pulses, 32'd0);
        check("sel_dat_cleared", rd, 32'd0);
        wb_xfer(32'h3000_1000, 1'b1, 4'b0011, 32'hF, lat, rd, a2);
        check("sel_en_kept", {28'd0, core_en}, 32'h5);

        // Out-of-window address
        acks_before = ack_total;
        wb_xfer(32'h3100_0000, 1'b1, 4'hF, 32'h1, lat, rd, a2);
        check("oow_no_ack", lat, 32'd0);
        check("oow_ack_total", ack_total - acks_before, 32'd0);
        check("oow_no_we", we_pulses, 32'd0);

        // Reset while the read sits in RD_WAIT
        @(negedge clk);
        adr = 32'h3000_0108; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        acks_before = ack_total;
        @(posedge clk); #1;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0; stb = 1'b0; cyc = 1'b0;
        check("mid_rst_core_en", {28'd0, core_en}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_ack", ack_total - acks_before, 32'd0);
        clear_mon();
        wb_xfer(32'h3000_0104, 1'b1, 4'hF, 32'hA5A5_0001, lat, rd, a2);
        check("post_rst_lat", lat, 32'd1);
        check("post_rst_we", {28'd0, last_we}, 32'h2);
        check("post_rst_addr", {26'd0, last_we_addr}, 32'd1);
        check("one_hot_exclusive", bad_cycles, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
